ps2_cmd_sequencer: RTL and testbench
====================================

Name: ps2_cmd_sequencer

Overview:
- Host-side command engine upstream of ps2_host_to_kb; replaces single-byte button-driven writes with acknowledged 1- or 2-byte keyboard commands (e.g. ED+LED mask, F3+typematic rate, FF reset).
- Loads each byte into the host-to-keyboard writer, then waits for the keyboard reply delivered by ps2_port.
- Handles resend and error retries and response timeouts, and reports done/fail to the requester.

Parameters:
- TIMEOUT_CYCLES, 24'd1600000, max clk cycles to wait for writer busy-rise or keyboard reply (~100 ms @16 MHz); counter width 24
- MAX_RETRIES, 2, resend/error retries allowed per byte before failure

Ports:
- clk  in  1  system clock, same domain as ps2_host_to_kb and ps2_port
- rst  in  1  synchronous, active-high reset
- cmd_start  in  1  1-cycle request strobe; sampled only in IDLE
- cmd_len  in  1  0 = one byte, 1 = two bytes
- cmd_byte0  in  8  first byte (command)
- cmd_byte1  in  8  second byte (argument), ignored when cmd_len=0
- ps2busy  in  1  writer busy, from ps2_host_to_kb
- ps2error  in  1  writer error flag, from ps2_host_to_kb
- kb_interrupt  in  1  1-cycle strobe when a new scancode is valid, from ps2_port
- scancode  in  8  received byte, from ps2_port
- data  out  8  byte to transmit, to ps2_host_to_kb
- dataload  out  1  1-cycle load strobe, to ps2_host_to_kb
- seq_busy  out  1  high from accepted cmd_start until DONE/FAIL
- seq_done  out  1  1-cycle pulse, all bytes acknowledged
- seq_fail  out  1  1-cycle pulse, retries exhausted or timeout
- last_resp  out  8  last byte received while in WAIT_ACK

Behaviour:
- Reset: state=IDLE; data=8'h00, dataload=0, seq_busy=0, seq_done=0, seq_fail=0, last_resp=8'h00; byte index, retry count and timer are cleared. Reset has priority in every state and aborts a sequence mid-flight without a done/fail pulse.
- On reset mid-sequence, the writer may still be transmitting. The block issues no further dataload until it leaves reset and sees a new cmd_start.
- IDLE: on cmd_start=1, latch cmd_len and both bytes, set idx=0 and retries=0, raise seq_busy, go to LOAD. cmd_start outside IDLE is ignored.
- LOAD: if ps2busy=1, stay. Otherwise drive data=byte[idx] and pulse dataload for exactly one cycle, clear the timer, go to WAIT_RISE.
- WAIT_RISE: on ps2busy=1, go to WAIT_TX. If the timer reaches TIMEOUT_CYCLES, go to FAIL.
- WAIT_TX: when ps2busy falls to 0:
  - ps2error=1 → RETRY.
  - ps2error=0 → clear the timer and go to WAIT_ACK.
- WAIT_ACK: on kb_interrupt=1, latch last_resp=scancode, then:
  - FA: if idx==cmd_len, go to DONE; else idx=idx+1, retries=0, go to LOAD.
  - FE: go to RETRY.
  - any other value: ignore (stray make/break code) and keep waiting; the timer is not cleared.
  - timer reaching TIMEOUT_CYCLES → FAIL.
- kb_interrupt arriving in the same cycle the timer expires: the response wins.
- RETRY: if retries==MAX_RETRIES, go to FAIL. Otherwise retries=retries+1 and go to LOAD with the same idx, resending the same byte.
- DONE: pulse seq_done for 1 cycle, drop seq_busy in that same cycle, go to IDLE.
- FAIL: pulse seq_fail for 1 cycle, drop seq_busy in that same cycle, go to IDLE.
- A cmd_start arriving in the cycle of the done/fail pulse is ignored; it is accepted from the next cycle, once IDLE.
- kb_interrupt outside WAIT_ACK is ignored, and last_resp is not updated.
- Timer saturates at TIMEOUT_CYCLES and does not wrap.
- data holds its last value between loads. dataload is never high on two consecutive cycles.

Test Plan:
- 1-byte FF: cmd_start, len=0, byte0=FF → one dataload with data=FF; model busy for 10 cycles, then reply FA → seq_done pulse, last_resp=FA, exactly one dataload total.
- 2-byte LED: len=1, bytes ED,07; reply FA after each byte → dataloads ED then 07 in order, seq_done after the second FA, none earlier.
- Resend: ED,07; reply FE to the first byte, then FA, then FA → dataload sequence ED,ED,07, then seq_done. With MAX_RETRIES=2, three FE replies to ED → three ED loads, then seq_fail.
- Errors and timeouts:
  - ps2error=1 at the busy falling edge on every attempt → MAX_RETRIES+1 loads, then seq_fail, with no wait for kb_interrupt.
  - no reply with TIMEOUT_CYCLES=100 → seq_fail exactly 100 cycles after entering WAIT_ACK (±1 registered).
- Stray code: reply AA, then 1C, then FA → last_resp steps AA→1C→FA, a single seq_done, no retry.
- Reset mid-flight: assert rst during WAIT_ACK → next cycle all outputs at reset values, no pulses. A new cmd_start after rst deasserts runs to completion normally.

Source files
------------

// File: rtl/ps2_cmd_sequencer_if.sv
// Bundles the requester, host-to-keyboard writer and keyboard-reply signals
// seen by ps2_cmd_sequencer; slave is the sequencer's view, master the environment's.
interface ps2_cmd_sequencer_if;
  logic       cmd_start;
  logic       cmd_len;
  logic [7:0] cmd_byte0;
  logic [7:0] cmd_byte1;
  logic       ps2busy;
  logic       ps2error;
  logic       kb_interrupt;
  logic [7:0] scancode;
  logic [7:0] data;
  logic       dataload;
  logic       seq_busy;
  logic       seq_done;
  logic       seq_fail;
  logic [7:0] last_resp;

  modport slave (
    input  cmd_start, cmd_len, cmd_byte0, cmd_byte1,
    input  ps2busy, ps2error, kb_interrupt, scancode,
    output data, dataload, seq_busy, seq_done, seq_fail, last_resp
  );

  modport master (
    output cmd_start, cmd_len, cmd_byte0, cmd_byte1,
    output ps2busy, ps2error, kb_interrupt, scancode,
    input  data, dataload, seq_busy, seq_done, seq_fail, last_resp
  );
endinterface

// File: rtl/ps2_cmd_sequencer.sv
// Sends 1- or 2-byte keyboard commands through ps2_host_to_kb, waits for the
// FA acknowledge, retries on FE / writer error, and reports done or fail.
module ps2_cmd_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1600000,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input logic                clk,
  input logic                rst,
  ps2_cmd_sequencer_if.slave bus
);

  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_WAIT_RISE = 3'd2;
  localparam logic [2:0] S_WAIT_TX   = 3'd3;
  localparam logic [2:0] S_WAIT_ACK  = 3'd4;
  localparam logic [2:0] S_RETRY     = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;
  localparam logic [2:0] S_FAIL      = 3'd7;

  localparam logic [7:0] KB_ACK    = 8'hFA;
  localparam logic [7:0] KB_RESEND = 8'hFE;

  logic [2:0]    state_q, state_d;
  logic          len_q, len_d;
  logic [7:0]    byte0_q, byte0_d;
  logic [7:0]    byte1_q, byte1_d;
  logic          idx_q, idx_d;
  logic [RW-1:0] retries_q, retries_d;
  logic [23:0]   timer_q, timer_d;
  logic [7:0]    data_q, data_d;
  logic          dataload_q, dataload_d;
  logic [7:0]    last_resp_q, last_resp_d;

  logic          timed_out;
  logic [23:0]   timer_sat;

  // The timer saturates so a long stall can never wrap back under the limit.
  assign timed_out = (timer_q == TIMEOUT_CYCLES);
  assign timer_sat = timed_out ? timer_q : timer_q + 24'd1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    len_d       = len_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    idx_d       = idx_q;
    retries_d   = retries_q;
    timer_d     = timer_sat;
    data_d      = data_q;
    dataload_d  = 1'b0;
    last_resp_d = last_resp_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_start) begin
          len_d     = bus.cmd_len;
          byte0_d   = bus.cmd_byte0;
          byte1_d   = bus.cmd_byte1;
          idx_d     = 1'b0;
          retries_d = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!bus.ps2busy) begin
          data_d     = idx_q ? byte1_q : byte0_q;
          dataload_d = 1'b1;
          timer_d    = '0;
          state_d    = S_WAIT_RISE;
        end
      end
      S_WAIT_RISE: begin
        if (bus.ps2busy)     state_d = S_WAIT_TX;
        else if (timed_out)  state_d = S_FAIL;
      end
      S_WAIT_TX: begin
        if (!bus.ps2busy) begin
          if (bus.ps2error) begin
            state_d = S_RETRY;
          end else begin
            timer_d = '0;
            state_d = S_WAIT_ACK;
          end
        end
      end
      S_WAIT_ACK: begin
        // A reply in the expiry cycle takes precedence over the timeout.
        if (bus.kb_interrupt) begin
          last_resp_d = bus.scancode;
          if (bus.scancode == KB_ACK) begin
            if (idx_q == len_q) begin
              state_d = S_DONE;
            end else begin
              idx_d     = idx_q + 1'b1;
              retries_d = '0;
              state_d   = S_LOAD;
            end
          end else if (bus.scancode == KB_RESEND) begin
            state_d = S_RETRY;
          end
        end else if (timed_out) begin
          state_d = S_FAIL;
        end
      end
      S_RETRY: begin
        if (retries_q == RW'(MAX_RETRIES)) begin
          state_d = S_FAIL;
        end else begin
          retries_d = retries_q + 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= 1'b0;
      byte0_q     <= 8'h00;
      byte1_q     <= 8'h00;
      idx_q       <= 1'b0;
      retries_q   <= '0;
      timer_q     <= '0;
      data_q      <= 8'h00;
      dataload_q  <= 1'b0;
      last_resp_q <= 8'h00;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state_q     <= state_d;
      len_q       <= len_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      idx_q       <= idx_d;
      retries_q   <= retries_d;
      timer_q     <= timer_d;
      data_q      <= data_d;
      dataload_q  <= dataload_d;
      last_resp_q <= last_resp_d;
    end
  end

  // Status is decoded from the state so done/fail and the busy drop share one cycle.
  assign bus.data      = data_q;
  assign bus.dataload  = dataload_q;
  assign bus.seq_busy  = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
  assign bus.seq_done  = (state_q == S_DONE);
  assign bus.seq_fail  = (state_q == S_FAIL);
  assign bus.last_resp = last_resp_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Self-checking bench for ps2_cmd_sequencer: writer/keyboard models, a load and
// outcome scoreboard, a vector table and hand-written multi-cycle sequences.
module tb_ps2_cmd_sequencer;

  localparam logic [23:0] TMO = 24'd100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_cmd_sequencer_if bus ();

  ps2_cmd_sequencer #(.TIMEOUT_CYCLES(TMO), .MAX_RETRIES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       fail;
    logic [7:0] resp;
  } out_t;

  // rep/ld hold bytes first-in-MSB; n_rep/n_ld say how many are valid.
  typedef struct packed {
    logic        len;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [47:0] rep;
    logic [2:0]  n_rep;
    logic        err;
    logic        stall;
    logic [31:0] ld;
    logic [2:0]  n_ld;
    logic        fail;
    logic [7:0]  resp;
    logic [9:0]  max_cyc;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fall_cyc = 0;
  int pulse_cyc = 0;

  logic [7:0] exp_load_q[$];
  logic [7:0] reply_q[$];
  out_t       exp_out_q[$];

  logic       err_mode     = 1'b0;
  logic       stall_mode   = 1'b0;
  logic       stray_in_tx  = 1'b0;
  logic [7:0] stray_expect = 8'h00;

  vec_t vecs[9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    logic [7:0] e;
    out_t       o;
    logic       prev_load;
    prev_load = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.dataload === 1'b1) begin
        check("load_not_back_to_back", prev_load, 1'b0);
        check("load_expected", exp_load_q.size() > 0, 1'b1);
        if (exp_load_q.size() > 0) begin
          e = exp_load_q.pop_front();
          check("load_data", bus.data, e);
        end
      end
      prev_load = (bus.dataload === 1'b1);
      if (bus.seq_done === 1'b1 || bus.seq_fail === 1'b1) begin
        check("pulse_expected", exp_out_q.size() > 0, 1'b1);
        if (exp_out_q.size() > 0) begin
          o = exp_out_q.pop_front();
          check("outcome_fail", bus.seq_fail, o.fail);
          check("outcome_done", bus.seq_done, !o.fail);
          check("last_resp_at_end", bus.last_resp, o.resp);
        end
        check("busy_low_at_pulse", bus.seq_busy, 1'b0);
        pulse_cyc = cyc;
      end
    end
  end

  // Writer + keyboard model: busy 10 cycles after each load, then replies.
  initial begin
    logic [7:0] r;
    bus.ps2busy      = 1'b0;
    bus.ps2error     = 1'b0;
    bus.kb_interrupt = 1'b0;
    bus.scancode     = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (bus.dataload === 1'b1 && !stall_mode) begin
        @(posedge clk); #1;
        bus.ps2busy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        if (stray_in_tx) begin
          bus.scancode     = 8'h5A;
          bus.kb_interrupt = 1'b1;
        end
        @(posedge clk); #1;
        bus.kb_interrupt = 1'b0;
        if (stray_in_tx) check("stray_outside_wait_ack", bus.last_resp, stray_expect);
        repeat (4) @(posedge clk);
        #1;
        bus.ps2busy  = 1'b0;
        bus.ps2error = err_mode;
        fall_cyc     = cyc;
        @(posedge clk); #1;
        bus.ps2error = 1'b0;
        while (!err_mode && reply_q.size() > 0) begin
          r = reply_q.pop_front();
          repeat (2) @(posedge clk);
          #1;
          bus.scancode     = r;
          bus.kb_interrupt = 1'b1;
          @(posedge clk); #1;
          bus.kb_interrupt = 1'b0;
          check("last_resp_step", bus.last_resp, r);
          if (r == 8'hFA || r == 8'hFE) break;
        end
      end
    end
  end

  task automatic start_cmd(input logic len, input logic [7:0] b0, input logic [7:0] b1);
    @(posedge clk); #1;
    bus.cmd_len   = len;
    bus.cmd_byte0 = b0;
    bus.cmd_byte1 = b1;
    bus.cmd_start = 1'b1;
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
    check("busy_after_start", bus.seq_busy, 1'b1);
  endtask

  task automatic wait_end(input string name, input int budget);
    int n;
    n = 0;
    while (!(bus.seq_done === 1'b1 || bus.seq_fail === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ended_in_budget"}, n < budget, 1'b1);
  endtask

  task automatic settle(input string name);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_loads_consumed"}, exp_load_q.size(), 0);
    check({name, "_replies_consumed"}, reply_q.size(), 0);
    exp_load_q.delete();
    reply_q.delete();
    exp_out_q.delete();
  endtask

  task automatic run_vec(input vec_t v, input int id);
    string nm;
    nm = $sformatf("vec%0d", id);
    err_mode   = v.err;
    stall_mode = v.stall;
    for (int i = 0; i < int'(v.n_ld); i++) exp_load_q.push_back(v.ld[31-8*i -: 8]);
    for (int i = 0; i < int'(v.n_rep); i++) reply_q.push_back(v.rep[47-8*i -: 8]);
    exp_out_q.push_back('{fail: v.fail, resp: v.resp});
    start_cmd(v.len, v.b0, v.b1);
    wait_end(nm, int'(v.max_cyc));
    settle(nm);
    err_mode   = 1'b0;
    stall_mode = 1'b0;
  endtask

  initial begin
    int delta;
    rst           = 1'b1;
    bus.cmd_start = 1'b0;
    bus.cmd_len   = 1'b0;
    bus.cmd_byte0 = 8'h00;
    bus.cmd_byte1 = 8'h00;

    //          len   b0     b1     replies                    n     err   stall loads                      n     fail  resp   budget
    vecs[0] = '{1'b0, 8'hFF, 8'h00, {8'hFA, 40'h0},            3'd1, 1'b0, 1'b0, {8'hFF, 24'h0},          3'd1, 1'b0, 8'hFA, 10'd300};
    vecs[1] = '{1'b1, 8'hED, 8'h07, {16'hFAFA, 32'h0},         3'd2, 1'b0, 1'b0, {16'hED07, 16'h0},       3'd2, 1'b0, 8'hFA, 10'd300};
    vecs[2] = '{1'b1, 8'hED, 8'h07, {24'hFEFAFA, 24'h0},       3'd3, 1'b0, 1'b0, {24'hEDED07, 8'h0},      3'd3, 1'b0, 8'hFA, 10'd300};
    vecs[3] = '{1'b1, 8'hED, 8'h07, {32'hFEFEFAFA, 16'h0},     3'd4, 1'b0, 1'b0, 32'hEDEDED07,            3'd4, 1'b0, 8'hFA, 10'd300};
    vecs[4] = '{1'b1, 8'hED, 8'h07, {24'hFEFEFE, 24'h0},       3'd3, 1'b0, 1'b0, {24'hEDEDED, 8'h0},      3'd3, 1'b1, 8'hFE, 10'd300};
    vecs[5] = '{1'b1, 8'hF3, 8'h20, 48'h0,                     3'd0, 1'b1, 1'b0, {24'hF3F3F3, 8'h0},      3'd3, 1'b1, 8'hFE, 10'd60};
    vecs[6] = '{1'b0, 8'hF4, 8'h00, {24'hAA1CFA, 24'h0},       3'd3, 1'b0, 1'b0, {8'hF4, 24'h0},          3'd1, 1'b0, 8'hFA, 10'd300};
    vecs[7] = '{1'b0, 8'hF5, 8'h00, 48'h0,                     3'd0, 1'b0, 1'b1, {8'hF5, 24'h0},          3'd1, 1'b1, 8'hFA, 10'd300};
    vecs[8] = '{1'b1, 8'hF3, 8'h20, {24'hFAAAFA, 24'h0},       3'd3, 1'b0, 1'b0, {16'hF320, 16'h0},       3'd2, 1'b0, 8'hFA, 10'd300};

    repeat (3) @(posedge clk);
    #1;
    check("rst_data", bus.data, 8'h00);
    check("rst_dataload", bus.dataload, 1'b0);
    check("rst_seq_busy", bus.seq_busy, 1'b0);
    check("rst_seq_done", bus.seq_done, 1'b0);
    check("rst_seq_fail", bus.seq_fail, 1'b0);
    check("rst_last_resp", bus.last_resp, 8'h00);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // cmd_start while busy and in the done-pulse cycle are both ignored;
    // a stray kb_interrupt during transmission must not touch last_resp.
    stray_in_tx  = 1'b1;
    stray_expect = 8'hFA;
    exp_load_q.push_back(8'hF2);
    reply_q.push_back(8'hFA);
    exp_out_q.push_back('{fail: 1'b0, resp: 8'hFA});
    start_cmd(1'b0, 8'hF2, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    bus.cmd_byte0 = 8'h55;
    bus.cmd_start = 1'b1;
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
    wait_end("ignore_start", 300);
    bus.cmd_byte0 = 8'h66;
    bus.cmd_start = 1'b1;
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
    stray_in_tx   = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("start_in_pulse_ignored", bus.seq_busy, 1'b0);
    settle("ignore_start");

    // No reply: fail roughly TIMEOUT_CYCLES after entering WAIT_ACK.
    exp_load_q.push_back(8'hEE);
    exp_out_q.push_back('{fail: 1'b1, resp: 8'hFA});
    start_cmd(1'b0, 8'hEE, 8'h00);
    wait_end("timeout", 400);
    delta = cyc - fall_cyc - 1;
    check("timeout_latency", (delta >= 99 && delta <= 101) ? 100 : delta, 100);
    settle("timeout");

    // Reset while waiting for the reply aborts silently.
    exp_load_q.push_back(8'hED);
    start_cmd(1'b1, 8'hED, 8'h07);
    repeat (30) @(posedge clk);
    #1;
    check("midflight_busy", bus.seq_busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_data", bus.data, 8'h00);
    check("mid_rst_dataload", bus.dataload, 1'b0);
    check("mid_rst_seq_busy", bus.seq_busy, 1'b0);
    check("mid_rst_seq_done", bus.seq_done, 1'b0);
    check("mid_rst_seq_fail", bus.seq_fail, 1'b0);
    check("mid_rst_last_resp", bus.last_resp, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("no_load_after_reset", bus.seq_busy, 1'b0);
    settle("midflight_rst");
    run_vec(vecs[1], 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
